// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU control codes and FSM state encodings.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational integer ALU shared by the arbiter; unknown control codes yield zero.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        ALUCnt,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] input1,
  input  logic [DATA_W-1:0] input2,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Operation select; SLL shifts input2 by shamt, SLT compares signed.
  always_comb begin
    result = {DATA_W{1'b0}};
    case (ALUCnt)
      ALU_AND: result = input1 & input2;
      ALU_OR:  result = input1 | input2;
      ALU_ADD: result = input1 + input2;
      ALU_SLL: result = input2 << shamt;
      ALU_SUB: result = input1 - input2;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(input1) < $signed(input2))};
      default: result = {DATA_W{1'b0}};
    endcase
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered-operand ALU between two valid/ready requesters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [7:0]            req_ALUCnt,
  input  logic [9:0]            req_shamt,
  input  logic [2*DATA_W-1:0]   req_input1,
  input  logic [2*DATA_W-1:0]   req_input2,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_zero,
  output logic                  busy,
  output logic                  owner
);

  arb_state_t        state_r, state_nxt_s;
  logic              prio_r, owner_r, grant_s, any_req_s, rsp_done_s;
  logic [3:0]        op_cnt_r;
  logic [4:0]        op_shamt_r;
  logic [DATA_W-1:0] op_in1_r, op_in2_r;
  logic [DATA_W-1:0] alu_result_s, rsp_result_r;
  logic              alu_zero_s, rsp_zero_r;

  assign any_req_s  = |req_valid;
  assign rsp_done_s = owner_r ? rsp_ready[1] : rsp_ready[0];

  // Grant selection: a lone requester wins, contention goes to the pointer.
  always_comb begin
    grant_s = 1'b0;
    case (req_valid)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = prio_r;
      default: grant_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_nxt_s = EXEC;
        else           state_nxt_s = IDLE;
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_done_s) state_nxt_s = IDLE;
        else            state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; req_ready is combinational so a grant costs no extra cycle.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) req_ready = grant_s ? 2'b10 : 2'b01;
        else           req_ready = 2'b00;
      end
      EXEC: busy = 1'b1;
      RESP: begin
        busy      = 1'b1;
        rsp_valid = owner_r ? 2'b10 : 2'b01;
      end
      default: busy = 1'b0;
    endcase
  end

  // Operand capture, result capture and priority update.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r       <= INIT_PRIO;
      owner_r      <= 1'b0;
      op_cnt_r     <= 4'd0;
      op_shamt_r   <= 5'd0;
      op_in1_r     <= {DATA_W{1'b0}};
      op_in2_r     <= {DATA_W{1'b0}};
      rsp_result_r <= {DATA_W{1'b0}};
      rsp_zero_r   <= 1'b0;
    end else begin
      if (state_r == IDLE && any_req_s) begin
        owner_r    <= grant_s;
        op_cnt_r   <= grant_s ? req_ALUCnt[7:4] : req_ALUCnt[3:0];
        op_shamt_r <= grant_s ? req_shamt[9:5]  : req_shamt[4:0];
        op_in1_r   <= grant_s ? req_input1[2*DATA_W-1:DATA_W] : req_input1[DATA_W-1:0];
        op_in2_r   <= grant_s ? req_input2[2*DATA_W-1:DATA_W] : req_input2[DATA_W-1:0];
      end
      if (state_r == EXEC) begin
        rsp_result_r <= alu_result_s;
        rsp_zero_r   <= alu_zero_s;
      end
      if (state_r == RESP && rsp_done_s) begin
        prio_r <= ~owner_r;
      end
    end
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .ALUCnt (op_cnt_r),
    .shamt  (op_shamt_r),
    .input1 (op_in1_r),
    .input2 (op_in2_r),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  assign rsp_result = rsp_result_r;
  assign rsp_zero   = rsp_zero_r;
  assign owner      = owner_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: latency, contention, back-pressure and mid-op reset.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [7:0]          req_ALUCnt;
  logic [9:0]          req_shamt;
  logic [2*DATA_W-1:0] req_input1;
  logic [2*DATA_W-1:0] req_input2;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_zero;
  logic                busy;
  logic                owner;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter #(.DATA_W(DATA_W), .INIT_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ALUCnt (req_ALUCnt),
    .req_shamt  (req_shamt),
    .req_input1 (req_input1),
    .req_input2 (req_input2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] cnt, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
    if (idx == 0) begin
      req_ALUCnt[3:0] = cnt; req_shamt[4:0] = sh;
      req_input1[31:0] = a;  req_input2[31:0] = b;
    end else begin
      req_ALUCnt[7:4] = cnt; req_shamt[9:5] = sh;
      req_input1[63:32] = a; req_input2[63:32] = b;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_ALUCnt = 8'd0; req_shamt = 10'd0; req_input1 = 64'd0; req_input2 = 64'd0;
    tick(); tick();
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_rvalid", 32'(rsp_valid), 32'd0);
    chk("rst_rready", 32'(req_ready), 32'd0);
    chk("rst_owner",  32'(owner), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero",   32'(rsp_zero), 32'd0);

    // req0 ADD 5+3
    rst = 1'b0; rsp_ready = 2'b11;
    set_req(0, ALU_ADD, 5'd0, 32'd5, 32'd3); req_valid = 2'b01;
    #1 chk("add_rdy", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b00;
    #1 chk("add_exec_rdy",  32'(req_ready), 32'd0);
    chk("add_exec_busy", 32'(busy), 32'd1);
    chk("add_exec_rv",   32'(rsp_valid), 32'd0);
    tick();
    chk("add_rv",   32'(rsp_valid), 32'd1);
    chk("add_res",  rsp_result, 32'd8);
    chk("add_zero", 32'(rsp_zero), 32'd0);
    chk("add_busy", 32'(busy), 32'd1);
    tick();
    chk("add_done_rv",   32'(rsp_valid), 32'd0);
    chk("add_done_busy", 32'(busy), 32'd0);

    // req1 SUB 7-7
    set_req(1, ALU_SUB, 5'd0, 32'd7, 32'd7); req_valid = 2'b10;
    #1 chk("sub_rdy", 32'(req_ready), 32'd2);
    tick(); req_valid = 2'b00;
    tick();
    chk("sub_rv",    32'(rsp_valid), 32'd2);
    chk("sub_res",   rsp_result, 32'd0);
    chk("sub_zero",  32'(rsp_zero), 32'd1);
    chk("sub_owner", 32'(owner), 32'd1);
    tick();

    // contention from reset: req0 first, then req1, then req0 again
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, ALU_OR, 5'd0, 32'd5, 32'd3);
    set_req(1, ALU_ADD, 5'd0, 32'd5, 32'd3);
    req_valid = 2'b11;
    #1 chk("cont_rdy0", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b10;
    tick();
    chk("cont_rv0",  32'(rsp_valid), 32'd1);
    chk("cont_res0", rsp_result, 32'd7);
    tick();
    chk("cont_rdy1", 32'(req_ready), 32'd2);
    tick(); req_valid = 2'b00;
    tick();
    chk("cont_rv1",  32'(rsp_valid), 32'd2);
    chk("cont_res1", rsp_result, 32'd8);
    tick();
    req_valid = 2'b11;
    #1 chk("cont_rdy_again", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b00;
    tick();
    chk("cont_res_again", rsp_result, 32'd7);
    chk("cont_own_again", 32'(owner), 32'd0);
    tick();

    // back-pressure: req0 ADD 10+20 held in RESP, req1 SUB 9-4 waiting
    rsp_ready = 2'b00;
    set_req(0, ALU_ADD, 5'd0, 32'd10, 32'd20);
    set_req(1, ALU_SUB, 5'd0, 32'd9, 32'd4);
    req_valid = 2'b01;
    #1 chk("bp_rdy0", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b10; rsp_ready = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_res", rsp_result, 32'd30);
      chk("bp_rdy", 32'(req_ready), 32'd0);
      chk("bp_rv",  32'(rsp_valid), 32'd1);
      tick();
    end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b11;
    #1 chk("bp_rdy1", 32'(req_ready), 32'd2);
    tick(); req_valid = 2'b00;
    #1 chk("bp_owner1", 32'(owner), 32'd1);
    tick();
    chk("bp_rv1",  32'(rsp_valid), 32'd2);
    chk("bp_res1", rsp_result, 32'd5);
    tick();

    // shift: 3 << 1
    set_req(0, ALU_SLL, 5'd1, 32'd0, 32'd3); req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    tick();
    chk("sll_res", rsp_result, 32'd6);
    chk("sll_rv",  32'(rsp_valid), 32'd1);
    tick();

    // reset during EXEC discards the op
    set_req(0, ALU_ADD, 5'd0, 32'd1, 32'd1); req_valid = 2'b01;
    tick(); req_valid = 2'b00; rst = 1'b1;
    #1 chk("mid_exec_busy", 32'(busy), 32'd1);
    tick(); rst = 1'b0;
    chk("mid_busy",  32'(busy), 32'd0);
    chk("mid_rv",    32'(rsp_valid), 32'd0);
    chk("mid_res",   rsp_result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    set_req(1, ALU_AND, 5'd0, 32'd12, 32'd10); req_valid = 2'b10;
    #1 chk("post_rdy", 32'(req_ready), 32'd2);
    tick(); req_valid = 2'b00;
    tick();
    chk("post_rv",   32'(rsp_valid), 32'd2);
    chk("post_res",  rsp_result, 32'd8);
    chk("post_zero", 32'(rsp_zero), 32'd0);
    tick();
    chk("post_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
